// File: rtl/fertiliser_tank_driver_if.sv
// fertiliser_tank_driver_if: command/status bundle between the fertilising controller and the tank driver
interface fertiliser_tank_driver_if #(parameter int LEVEL_W = 8);
  logic fertilising, cleaning, refill_pulse;
  logic dose_valve, flush_valve, critical_level, empty_tank, busy;
  logic [LEVEL_W-1:0] level;
  modport master(
    output fertilising, cleaning, refill_pulse,
    input dose_valve, flush_valve, critical_level, empty_tank, busy, level
  );
  modport slave(
    input fertilising, cleaning, refill_pulse,
    output dose_valve, flush_valve, critical_level, empty_tank, busy, level
  );
endinterface

// File: rtl/fertiliser_tank_driver.sv
// fertiliser_tank_driver: drives dose/flush valves and tracks tank level from refills and timed dosing
module fertiliser_tank_driver #(
  parameter int LEVEL_W = 8,
  parameter int CAPACITY = 200,
  parameter int CRITICAL = 32,
  parameter int DOSE_TICKS = 16,
  parameter int FLUSH_CYCLES = 64
) (
  input logic clock,
  input logic reset,
  fertiliser_tank_driver_if.slave bus
);
  localparam int TW = $clog2(DOSE_TICKS + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TW-1:0] TICK_TOP = TW'(DOSE_TICKS - 1);
  localparam logic [FW-1:0] FLUSH_TOP = FW'(FLUSH_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] CAP = LEVEL_W'(CAPACITY);
  localparam logic [LEVEL_W-1:0] CRIT = LEVEL_W'(CRITICAL);
  typedef enum logic [1:0] {IDLE, DOSE, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [LEVEL_W-1:0] level, level_nx, drained;
  logic [TW-1:0] tick, tick_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic dec;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      level <= '0;
      tick <= '0;
      fcnt <= '0;
    end else begin
      state <= state_nx;
      level <= level_nx;
      tick <= tick_nx;
      fcnt <= fcnt_nx;
    end
  always_comb begin
    state_nx = state;
    tick_nx = tick;
    fcnt_nx = fcnt;
    dec = 1'b0;
    case (state)
      IDLE:
        if (bus.cleaning) begin
          state_nx = FLUSH;
          fcnt_nx = FLUSH_TOP;
        end else if (bus.fertilising && level != '0) begin
          state_nx = DOSE;
          tick_nx = TICK_TOP;
        end
      DOSE:
        if (!bus.fertilising) state_nx = IDLE;
        else if (tick == '0) begin
          dec = level != '0;
          tick_nx = TICK_TOP;
        end else tick_nx = tick - 1'b1;
      FLUSH:
        if (fcnt == '0) state_nx = DONE;
        else fcnt_nx = fcnt - 1'b1;
      DONE: if (!bus.cleaning) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // a refill landing on a decrement cycle cancels it, so saturation is judged after the drain
    drained = level - LEVEL_W'(dec);
    level_nx = (bus.refill_pulse && drained < CAP) ? drained + 1'b1 : drained;
    if (state == FLUSH) level_nx = (fcnt == '0) ? '0 : level;
    if (state == DOSE && dec && level_nx == '0) state_nx = IDLE;
  end
  assign bus.dose_valve = state == DOSE;
  assign bus.flush_valve = state == FLUSH;
  assign bus.busy = state != IDLE;
  assign bus.level = level;
  assign bus.empty_tank = level == '0;
  assign bus.critical_level = level <= CRIT;
endmodule

// File: tb/tb_fertiliser_tank_driver.sv
// tb_fertiliser_tank_driver: directed vectors with hand-computed expectations for the tank driver
module tb_fertiliser_tank_driver;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  fertiliser_tank_driver_if #(.LEVEL_W(8)) bus();
  fertiliser_tank_driver dut(.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic refill(input int n);
    repeat (n) begin
      bus.refill_pulse = 1'b1;
      step(1);
      bus.refill_pulse = 1'b0;
    end
  endtask
  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.fertilising = 1'b0;
    bus.cleaning = 1'b0;
    bus.refill_pulse = 1'b0;
    step(2);
    check("rst_level", bus.level, 0);
    check("rst_empty", bus.empty_tank, 1);
    check("rst_crit", bus.critical_level, 1);
    check("rst_dose", bus.dose_valve, 0);
    check("rst_flush", bus.flush_valve, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b1;
    step(1);
    refill(32);
    check("lvl32", bus.level, 32);
    check("crit32", bus.critical_level, 1);
    refill(1);
    check("lvl33", bus.level, 33);
    check("crit33", bus.critical_level, 0);
    check("empty33", bus.empty_tank, 0);
    refill(7);
    check("lvl40", bus.level, 40);
    bus.fertilising = 1'b1;
    check("dose_pre", bus.dose_valve, 0);
    step(1);
    check("dose_open", bus.dose_valve, 1);
    check("dose_busy", bus.busy, 1);
    step(15);
    check("dose_t15", bus.level, 40);
    step(1);
    check("dose_t16", bus.level, 39);
    step(48);
    check("dose_t64", bus.level, 36);
    step(5);
    bus.fertilising = 1'b0;
    step(1);
    check("dose_stop", bus.dose_valve, 0);
    check("dose_idle", bus.busy, 0);
    step(20);
    check("partial_tick", bus.level, 36);
    do_reset();
    refill(2);
    bus.fertilising = 1'b1;
    step(1);
    check("dry_open", bus.dose_valve, 1);
    step(16);
    check("dry_lvl1", bus.level, 1);
    step(16);
    check("dry_lvl0", bus.level, 0);
    check("dry_empty", bus.empty_tank, 1);
    check("dry_valve", bus.dose_valve, 0);
    check("dry_busy", bus.busy, 0);
    step(5);
    check("dry_noreent", bus.dose_valve, 0);
    bus.fertilising = 1'b0;
    refill(20);
    check("fl_lvl20", bus.level, 20);
    bus.cleaning = 1'b1;
    step(1);
    check("fl_open", bus.flush_valve, 1);
    refill(3);
    check("fl_norefill", bus.level, 20);
    step(60);
    check("fl_c64", bus.flush_valve, 1);
    step(1);
    check("fl_closed", bus.flush_valve, 0);
    check("fl_level", bus.level, 0);
    check("fl_done_busy", bus.busy, 1);
    step(5);
    check("fl_once", bus.flush_valve, 0);
    check("fl_hold_busy", bus.busy, 1);
    bus.cleaning = 1'b0;
    step(1);
    check("fl_release", bus.busy, 0);
    refill(5);
    bus.fertilising = 1'b1;
    bus.cleaning = 1'b1;
    step(1);
    check("pri_flush", bus.flush_valve, 1);
    check("pri_nodose", bus.dose_valve, 0);
    bus.fertilising = 1'b0;
    step(64);
    check("pri_level", bus.level, 0);
    bus.cleaning = 1'b0;
    step(1);
    refill(3);
    bus.fertilising = 1'b1;
    step(16);
    bus.refill_pulse = 1'b1;
    step(1);
    bus.refill_pulse = 1'b0;
    check("net_zero", bus.level, 3);
    check("net_dose", bus.dose_valve, 1);
    step(16);
    check("net_next", bus.level, 2);
    bus.fertilising = 1'b0;
    step(1);
    refill(196);
    check("lvl198", bus.level, 198);
    refill(5);
    check("sat200", bus.level, 200);
    bus.cleaning = 1'b1;
    step(10);
    check("mid_flush", bus.flush_valve, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_flush", bus.flush_valve, 0);
    check("arst_dose", bus.dose_valve, 0);
    check("arst_level", bus.level, 0);
    bus.cleaning = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    check("post_busy", bus.busy, 0);
    check("post_level", bus.level, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
